// File: rtl/din_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : din_debounce
//  Description : Synchronises a raw asynchronous level, rejects pulses
//                shorter than STABLE_CYCLES samples, and emits a one-cycle
//                rise/fall pulse on each accepted transition of dout.
//  Revision    : 1.0  initial release
// ============================================================================
module din_debounce #(
  parameter int   SYNC_STAGES   = 2,    // synchroniser depth, 2..4
  parameter int   STABLE_CYCLES = 8,    // samples required to accept a change, >=2
  parameter logic RESET_VAL     = 1'b0  // level of sync chain and dout in reset
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic en,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  localparam logic [CNT_W-1:0] c_cnt_zero = '0;
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_PEND_HI   = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_PEND_LO   = 2'd3
  } state_t;

  localparam state_t c_reset_state = RESET_VAL ? ST_STABLE_HI : ST_STABLE_LO;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;

  state_t           r_state,  w_state_nxt;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
  logic             r_dout,   w_dout_nxt;
  logic             r_rise,   w_rise_nxt;
  logic             r_fall,   w_fall_nxt;
  logic             r_busy,   w_busy_nxt;

  // Synchroniser shift chain; runs regardless of en so the sample stays fresh.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Filter state and all outputs are registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_reset_state;
      r_cnt   <= c_cnt_zero;
      r_dout  <= RESET_VAL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dout  <= w_dout_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state logic: en=0 holds everything and only lets the pulses drop.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dout_nxt  = r_dout;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;

    if (en) begin
      case (r_state)
        ST_STABLE_LO: begin
          if (w_s) begin
            w_state_nxt = ST_PEND_HI;
            w_cnt_nxt   = c_cnt_one;
          end
        end
        ST_PEND_HI: begin
          if (!w_s) begin
            // Opposite sample: glitch rejected, stay low with no pulse.
            w_state_nxt = ST_STABLE_LO;
            w_cnt_nxt   = c_cnt_zero;
          end else if (r_cnt == c_cnt_last) begin
            w_state_nxt = ST_STABLE_HI;
            w_cnt_nxt   = c_cnt_zero;
            w_dout_nxt  = 1'b1;
            w_rise_nxt  = 1'b1;
          end else if (r_cnt != c_cnt_max) begin
            w_cnt_nxt   = r_cnt + c_cnt_one;
          end
        end
        ST_STABLE_HI: begin
          if (!w_s) begin
            w_state_nxt = ST_PEND_LO;
            w_cnt_nxt   = c_cnt_one;
          end
        end
        ST_PEND_LO: begin
          if (w_s) begin
            w_state_nxt = ST_STABLE_HI;
            w_cnt_nxt   = c_cnt_zero;
          end else if (r_cnt == c_cnt_last) begin
            w_state_nxt = ST_STABLE_LO;
            w_cnt_nxt   = c_cnt_zero;
            w_dout_nxt  = 1'b0;
            w_fall_nxt  = 1'b1;
          end else if (r_cnt != c_cnt_max) begin
            w_cnt_nxt   = r_cnt + c_cnt_one;
          end
        end
        default: begin
          w_state_nxt = c_reset_state;
          w_cnt_nxt   = c_cnt_zero;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt == ST_PEND_HI) || (w_state_nxt == ST_PEND_LO);
  end

  assign dout = r_dout;
  assign rise = r_rise;
  assign fall = r_fall;
  assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_din_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_din_debounce
//  Description : Directed, table-driven bench for din_debounce at default
//                parameters, plus hand sequences for multi-cycle corners.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_din_debounce;

  logic clk;
  logic reset;
  logic din;
  logic en;
  logic dout;
  logic rise;
  logic fall;
  logic busy;

  int n_tests;
  int n_fail;

  typedef struct {
    logic din;
    logic en;
    logic dout;
    logic rise;
    logic fall;
    logic busy;
  } vec_t;

  vec_t vecs[$];

  din_debounce #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(8),
    .RESET_VAL    (1'b0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .en   (en),
    .dout (dout),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input int n, input logic d, input logic e,
                     input logic xd, input logic xr, input logic xf, input logic xb);
    vec_t v;
    v.din = d; v.en = e; v.dout = xd; v.rise = xr; v.fall = xf; v.busy = xb;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rise_cnt;
    int fall_cnt;
    int rise_edge;

    n_tests = 0;
    n_fail  = 0;

    // Rows are the expected {dout,rise,fall,busy} after each edge.
    // Reset release with din=1 already high: accept on edge 10.
    add(2, 1, 1, 0, 0, 0, 0);
    add(7, 1, 1, 0, 0, 0, 1);
    add(1, 1, 1, 1, 1, 0, 0);
    add(2, 1, 1, 1, 0, 0, 0);
    // From dout=1, din=0 held: single fall on edge 10 after change.
    add(2, 0, 1, 1, 0, 0, 0);
    add(7, 0, 1, 1, 0, 0, 1);
    add(1, 0, 1, 0, 0, 1, 0);
    add(10, 0, 1, 0, 0, 0, 0);
    // From dout=0, din=1 for 5 cycles: busy 5 cycles, rejected.
    add(2, 1, 1, 0, 0, 0, 0);
    add(3, 1, 1, 0, 0, 0, 1);
    add(2, 0, 1, 0, 0, 0, 1);
    add(6, 0, 1, 0, 0, 0, 0);

    reset = 1'b1;
    din   = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_state", {4'b0, dout, rise, fall, busy}, 8'b0);
    end
    reset = 1'b0;

    foreach (vecs[i]) begin
      din = vecs[i].din;
      en  = vecs[i].en;
      tick();
      chk($sformatf("vec[%0d]", i), {4'b0, dout, rise, fall, busy},
          {4'b0, vecs[i].dout, vecs[i].rise, vecs[i].fall, vecs[i].busy});
    end

    // Enable freeze: 4 busy cycles, 6 frozen, accept 4 edges after en=1.
    din = 1'b1;
    en  = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("en_pre[%0d]", k), {6'b0, dout, busy}, {6'b0, 1'b0, (k >= 3)});
    end
    en = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("en_frozen[%0d]", k), {5'b0, dout, rise, busy}, 8'b0000_0001);
    end
    en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k < 4)
        chk($sformatf("en_resume[%0d]", k), {5'b0, dout, rise, busy}, 8'b0000_0001);
      else
        chk("en_accept", {5'b0, dout, rise, busy}, 8'b0000_0110);
    end

    // Async reset mid-pending at cnt=5 discards the change.
    reset = 1'b1;
    din   = 1'b0;
    tick();
    reset = 1'b0;
    din   = 1'b1;
    for (int k = 1; k <= 7; k++) tick();
    chk("rst_pre_busy", {7'b0, busy}, 8'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("rst_async", {5'b0, dout, rise, busy}, 8'b0);
    tick();
    chk("rst_held", {5'b0, dout, rise, busy}, 8'b0);
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k < 10)
        chk($sformatf("rst_restart[%0d]", k), {6'b0, dout, rise}, 8'b0);
      else
        chk("rst_restart_rise", {6'b0, dout, rise}, 8'b0000_0011);
    end

    // Return to low, then chatter every 3 cycles before a clean high.
    din = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    chk("chatter_start_low", {7'b0, dout}, 8'b0);
    rise_cnt  = 0;
    fall_cnt  = 0;
    rise_edge = -1;
    for (int c = 0; c < 30; c++) begin
      din = (((c / 3) % 2) == 0);
      tick();
      if (rise) rise_cnt++;
      if (fall) fall_cnt++;
    end
    chk("chatter_no_rise", 8'(rise_cnt), 8'd0);
    din = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (rise) begin
        rise_cnt++;
        if (rise_edge < 0) rise_edge = k;
      end
      if (fall) fall_cnt++;
    end
    chk("chatter_rise_count", 8'(rise_cnt), 8'd1);
    chk("chatter_rise_edge", 8'(rise_edge), 8'd10);
    chk("chatter_fall_count", 8'(fall_cnt), 8'd0);
    chk("chatter_final_dout", {7'b0, dout}, 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
